// File: rtl/alu_share_ctrl_pkg.sv
// Shared types for the time-shared ALU controller: ALU opcodes, FSM states
// and the operand bundle handed to the ALU.
package alu_share_ctrl_pkg;

   localparam logic [2:0] ALU_FWD = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_MUL = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SR  = 3'b110;
   localparam logic [2:0] ALU_ROR = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0] data1;
      logic [7:0] data2;
      logic [2:0] select;
   } alu_op_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping at NREQ. Returns a one-hot grant and the encoded winner.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  id
);

   int             pos;
   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      pos   = 0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         idx = IDW'(pos);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            id         = idx;
         end
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one 8-bit ALU between NREQ requesters.
// Optional counters STAT_OPS/STAT_STALL are built when ALU_SHARE_STATS_EN is defined.
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_data1,
   input  logic [NREQ*8-1:0] req_data2,
   input  logic [NREQ*3-1:0] req_select,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [7:0]        rsp_result,
   output logic              rsp_zero,
   output logic [7:0]        alu_data1,
   output logic [7:0]        alu_data2,
   output logic [2:0]        alu_select,
   input  logic [7:0]        alu_result,
   input  logic              alu_zero
`ifdef ALU_SHARE_STATS_EN
   ,
   output logic [15:0]       stat_ops,
   output logic [15:0]       stat_stall
`endif
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   if (NREQ < 2 || NREQ > 8 || WAIT_CYCLES < 1) begin : g_bad_cfg
      $error("alu_share_ctrl: NREQ must be 2..8 and WAIT_CYCLES >= 1");
   end

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr, cur_id, win_id;
   logic [NREQ-1:0] grant;
   logic [CW-1:0]   cnt;
   logic            accept, last_wait;
   alu_op_t         ops [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign ops[i] = '{data1:  req_data1[8*i +: 8],
                        data2:  req_data2[8*i +: 8],
                        select: req_select[3*i +: 3]};
   end

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .id    (win_id)
   );

   assign accept    = (state == ST_IDLE) && (|req_valid);
   assign last_wait = (cnt == CW'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept)            state_nxt = ST_EXEC;
         ST_EXEC: if (last_wait)         state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready[cur_id]) state_nxt = ST_IDLE;
         default:                        state_nxt = ST_IDLE;
      endcase
   end

   // Ready is gated by reset so an asserted reset silences the grant at once.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state == ST_IDLE && reset_n) req_ready = grant;
      if (state == ST_RESP)            rsp_valid[cur_id] = 1'b1;
   end

   // ALU operands only move on accept, so the ALU sees no activity while idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr        <= '0;
         cur_id     <= '0;
         cnt        <= '0;
         alu_data1  <= '0;
         alu_data2  <= '0;
         alu_select <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else if (accept) begin
         alu_data1  <= ops[win_id].data1;
         alu_data2  <= ops[win_id].data2;
         alu_select <= ops[win_id].select;
         cur_id     <= win_id;
         cnt        <= CW'(WAIT_CYCLES);
         ptr        <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
      end else if (state == ST_EXEC) begin
         cnt <= cnt - CW'(1);
         if (last_wait) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
         end
      end
   end

`ifdef ALU_SHARE_STATS_EN
   logic stall;
   assign stall = |(req_valid & ~req_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_ops   <= '0;
         stat_stall <= '0;
      end else begin
         if (accept && stat_ops != 16'hFFFF)  stat_ops   <= stat_ops + 16'd1;
         if (stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl (NREQ=4, WAIT_CYCLES=2) with a one-cycle-latency ALU model.
module tb_alu_share_ctrl;
   import alu_share_ctrl_pkg::*;

   localparam int NREQ  = 4;
   localparam int WAITC = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [31:0] req_data1, req_data2;
   logic [11:0] req_select;
   logic [7:0]  rsp_result, alu_data1, alu_data2, alu_result;
   logic        rsp_zero, alu_zero;
   logic [2:0]  alu_select;
`ifdef ALU_SHARE_STATS_EN
   logic [15:0] stat_ops, stat_stall;
`endif

   logic [7:0] op_a [4];
   logic [7:0] op_b [4];
   logic [2:0] op_s [4];

   int total = 0;
   int bad   = 0;

   assign req_data1  = {op_a[3], op_a[2], op_a[1], op_a[0]};
   assign req_data2  = {op_b[3], op_b[2], op_b[1], op_b[0]};
   assign req_select = {op_s[3], op_s[2], op_s[1], op_s[0]};

   always #5 clk = ~clk;

   alu_share_ctrl #(.NREQ(NREQ), .WAIT_CYCLES(WAITC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data1  (req_data1),
      .req_data2  (req_data2),
      .req_select (req_select),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .alu_data1  (alu_data1),
      .alu_data2  (alu_data2),
      .alu_select (alu_select),
      .alu_result (alu_result),
      .alu_zero   (alu_zero)
`ifdef ALU_SHARE_STATS_EN
      ,
      .stat_ops   (stat_ops),
      .stat_stall (stat_stall)
`endif
   );

   function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      logic [7:0]  r;
      logic [15:0] m;
      m = 16'(a) * 16'(b);
      case (s)
         ALU_FWD: r = a;
         ALU_ADD: r = a + b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_MUL: r = m[7:0];
         ALU_SLL: r = a << b[2:0];
         ALU_SR:  r = a >> b[2:0];
         default: r = (a >> b[2:0]) | (a << (4'd8 - {1'b0, b[2:0]}));
      endcase
      return {(r == 8'd0), r};
   endfunction

   // ALU needs a clock edge to settle: result reflects operands one edge late.
   always_ff @(posedge clk) {alu_zero, alu_result} <= alu_f(alu_select, alu_data1, alu_data2);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic do_op(input int id, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic z);
      int n;
      @(negedge clk);
      op_s[id] = s; op_a[id] = a; op_b[id] = b;
      req_valid = 4'b0001 << id;
      #1 chk("op_ready", req_ready, 4'b0001 << id);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      n = 0;
      while (rsp_valid == 4'd0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("op_latency", n, WAITC);
      chk("op_rsp_valid", rsp_valid, 4'b0001 << id);
      chk("op_result", rsp_result, r);
      chk("op_zero", rsp_zero, z);
      chk("op_alu_select", alu_select, s);
      rsp_ready = 4'b0001 << id;
      @(negedge clk);
      chk("op_release", rsp_valid, 0);
      rsp_ready = '0;
   endtask

   typedef struct {
      int         id;
      logic [2:0] s;
      logic [7:0] a, b, r;
      logic       z;
   } vec_t;

   vec_t vt [10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int        n;
      int        acc_id[$];
      int        acc_cyc[$];
      int        ptr_m, busy, cur, age, acc_w, w, ops_m, stall_m;
      logic [3:0] exp_rdy, exp_rsp;
      logic [8:0] exp_res;

      vt[0] = '{0, ALU_ADD, 8'd5,  8'd3,  8'd8,  1'b0};
      vt[1] = '{2, ALU_AND, 8'hF0, 8'h0F, 8'h00, 1'b1};
      vt[2] = '{1, ALU_OR,  8'hA0, 8'h05, 8'hA5, 1'b0};
      vt[3] = '{3, ALU_MUL, 8'h10, 8'h10, 8'h00, 1'b1};
      vt[4] = '{0, ALU_SLL, 8'h81, 8'h01, 8'h02, 1'b0};
      vt[5] = '{1, ALU_SR,  8'h80, 8'h07, 8'h01, 1'b0};
      vt[6] = '{2, ALU_ROR, 8'h01, 8'h01, 8'h80, 1'b0};
      vt[7] = '{3, ALU_FWD, 8'h3C, 8'h99, 8'h3C, 1'b0};
      vt[8] = '{1, ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1};
      vt[9] = '{3, ALU_MUL, 8'h07, 8'h06, 8'h2A, 1'b0};

      for (int i = 0; i < 4; i++) begin
         op_a[i] = '0; op_b[i] = '0; op_s[i] = '0;
      end
      reset_n   = 1'b0;
      req_valid = 4'hF;
      rsp_ready = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_data1", alu_data1, 0);
      req_valid = '0;
      reset_n   = 1'b1;

      // Table-driven single operations, each through the full handshake.
      for (int i = 0; i < 10; i++) do_op(vt[i].id, vt[i].s, vt[i].a, vt[i].b, vt[i].r, vt[i].z);

      // Asynchronous reset mid-cycle while requests are pending.
      @(negedge clk);
      req_valid = 4'hF;
      #1 reset_n = 1'b0;
      #1;
      chk("t1_req_ready", req_ready, 0);
      chk("t1_rsp_valid", rsp_valid, 0);
      chk("t1_rsp_result", rsp_result, 0);
      chk("t1_rsp_zero", rsp_zero, 0);
      chk("t1_alu_data1", alu_data1, 0);
      chk("t1_alu_data2", alu_data2, 0);
      chk("t1_alu_select", alu_select, 0);
      for (int i = 0; i < 4; i++) begin
         op_s[i] = ALU_ADD; op_a[i] = 8'(i * 10 + 1); op_b[i] = 8'(i);
      end
      rsp_ready = 4'hF;
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("t1_after_release", req_ready, 4'b0001);

      // All requesters valid continuously: strict rotation, one op per WAITC+2 edges.
      for (int cyc = 0; cyc < 18; cyc++) begin
         if (req_ready != 4'd0) begin
            for (int k = 0; k < 4; k++) if (req_ready[k]) acc_id.push_back(k);
            acc_cyc.push_back(cyc);
         end
         if (rsp_valid != 4'd0) begin
            for (int k = 0; k < 4; k++)
               if (rsp_valid[k]) chk("t4_result", rsp_result, {24'd0, alu_f(op_s[k], op_a[k], op_b[k])});
         end
         @(negedge clk);
         #1;
      end
      chk("t4_accept_count", acc_id.size(), 5);
      for (int k = 0; k < 5 && k < acc_id.size(); k++) chk("t4_order", acc_id[k], k % 4);
      for (int k = 1; k < 5 && k < acc_cyc.size(); k++) chk("t4_spacing", acc_cyc[k] - acc_cyc[k-1], WAITC + 2);
`ifdef ALU_SHARE_STATS_EN
      chk("t4_stat_ops", stat_ops, acc_id.size());
`endif
      req_valid = '0;
      repeat (6) @(negedge clk);

      // Response held off by its owner; other RSP_READY bits must be ignored.
      op_s[1] = ALU_SR; op_a[1] = 8'hC8; op_b[1] = 8'h03;
      req_valid = 4'b0010;
      rsp_ready = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      op_s[0] = ALU_FWD; op_a[0] = 8'h55; op_b[0] = 8'h00;
      req_valid = 4'b0001;
      n = 0;
      while (rsp_valid == 4'd0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         chk("t5_rsp_valid", rsp_valid, 4'b0010);
         chk("t5_rsp_result", rsp_result, 8'h19);
         chk("t5_req_ready", req_ready, 0);
         @(negedge clk);
      end
      rsp_ready = 4'b0011;
      @(negedge clk);
      chk("t5_released", rsp_valid, 0);
      chk("t5_next_ready", req_ready, 4'b0001);
      #1;
      req_valid = '0;
      rsp_ready = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_drop_no_op", rsp_valid, 0);
         chk("t5_alu_hold", alu_data1, 8'hC8);
      end

      // Reset while an operation is in flight discards it and rewinds the pointer.
      op_s[0] = ALU_ADD; op_a[0] = 8'h11; op_b[0] = 8'h22;
      req_valid = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      reset_n = 1'b0;
      #1 chk("t6_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      chk("t6_rsp_valid_rst", rsp_valid, 0);
      reset_n   = 1'b1;
      req_valid = 4'hF;
      #1 chk("t6_ptr_zero", req_ready, 4'b0001);
`ifdef ALU_SHARE_STATS_EN
      chk("t6_stat_ops_zero", stat_ops, 0);
`endif
      #1 req_valid = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t6_no_rsp", rsp_valid, 0);
      end

      // Random traffic against a transaction-level reference.
      ptr_m = 0; busy = 0; cur = 0; age = 0; acc_w = -1; w = 0; ops_m = 0; stall_m = 0;
      exp_res = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (acc_w >= 0) begin
            req_valid[acc_w] = 1'b0;
            acc_w = -1;
         end
         for (int i = 0; i < 4; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               op_a[i] = 8'($urandom);
               op_b[i] = 8'($urandom);
               op_s[i] = 3'($urandom);
               req_valid[i] = 1'b1;
            end
         end
         rsp_ready = 4'($urandom);
         #1;
         exp_rdy = '0;
         if (busy == 0 && req_valid != 4'd0) begin
            w = -1;
            for (int k = 0; k < 4; k++)
               if (w < 0 && req_valid[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
            exp_rdy = 4'b0001 << w;
         end
         chk("rnd_req_ready", req_ready, exp_rdy);
         exp_rsp = (busy != 0 && age >= WAITC) ? (4'b0001 << cur) : 4'd0;
         chk("rnd_rsp_valid", rsp_valid, exp_rsp);
         if (exp_rsp != 4'd0) begin
            chk("rnd_result", rsp_result, exp_res[7:0]);
            chk("rnd_zero", rsp_zero, exp_res[8]);
         end
         if ((req_valid & ~exp_rdy) != 4'd0) stall_m++;
         if (exp_rdy != 4'd0) begin
            busy = 1; cur = w; age = 0; acc_w = w; ops_m++;
            exp_res = alu_f(op_s[w], op_a[w], op_b[w]);
            ptr_m = (w + 1) % 4;
         end else if (busy != 0) begin
            if (age >= WAITC && rsp_ready[cur]) busy = 0;
            else age++;
         end
      end
      @(posedge clk);
      #1;
`ifdef ALU_SHARE_STATS_EN
      chk("rnd_stat_ops", stat_ops, ops_m);
      chk("rnd_stat_stall", stat_stall, stall_m);
`endif
      chk("rnd_some_ops", (ops_m > 50) ? 1 : 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
